// File: rtl/summercpu_pkg.sv
// Shared constants and types for the summercpu register-file write path.
//   REG_ADDR_W    : register address width
//   DATA_W        : register data width
//   WB_FIFO_DEPTH : entries in the B-result write-back queue
//   STARVE_LIMIT  : cycles the queue head may wait before A is stalled
package summercpu_pkg;
  localparam int REG_ADDR_W    = 5;
  localparam int DATA_W        = 32;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int STARVE_LIMIT  = 4;
  localparam int NUM_REGS      = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wr_arbiter_wb_fifo.sv
// wb_fifo: small synchronous FIFO holding pending B write-backs.
// Ports:
//   clk, reset : clock, synchronous active-low reset (empties the queue)
//   push, din  : enqueue din (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   full/empty : registered occupancy flags
//   head       : oldest entry; stale when empty, so callers gate on empty
module wb_fifo
  import summercpu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  localparam int PTR_W = (WB_FIFO_DEPTH > 1) ? $clog2(WB_FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(WB_FIFO_DEPTH - 1);

  wb_entry_t          mem [WB_FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W:0]     count;
  logic               do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(WB_FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: merges pipeline write-back (A) and multi-cycle unit
// results (B) onto the single register-file write port.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   a_wr, a_addr, a_data       : A write request (no handshake, priority)
//   b_valid/b_ready, b_addr/b_data : B result handshake into a 2-entry queue
//   iss_valid, iss_addr        : B issue, marks destination pending
//   busy_vec                   : per-register pending flags (bit 0 always 0)
//   stall_a                    : A must hold its write-back this cycle
//   wr, addr3, data3           : register-file write port
module regfile_wr_arbiter
  import summercpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_wr,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_addr,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  stall_a,
  output logic                  wr,
  output logic [REG_ADDR_W-1:0] addr3,
  output logic [DATA_W-1:0]     data3
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic              full, empty, push, b_pop, a_win;
  wb_entry_t         head, din;
  logic [CNT_W-1:0]  starve_cnt;
  logic [NUM_REGS-1:0] set_vec, clr_vec;

  // Ready follows occupancy before this cycle's pop, so a full queue
  // refuses even while draining.
  assign b_ready = reset && !full;
  assign push    = b_valid && b_ready;
  assign din     = '{addr: b_addr, data: b_data};

  assign stall_a = (starve_cnt == CNT_W'(STARVE_LIMIT)) && !empty;
  assign a_win   = a_wr && !stall_a;
  assign b_pop   = !a_win && !empty;

  wb_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (b_pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Write port: r0 writes still consume the slot but never assert wr.
  always_comb begin
    wr    = 1'b0;
    addr3 = '0;
    data3 = '0;
    if (a_win) begin
      wr    = (a_addr != '0);
      addr3 = a_addr;
      data3 = a_data;
    end else if (b_pop) begin
      wr    = (head.addr != '0);
      addr3 = head.addr;
      data3 = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)                          starve_cnt <= '0;
    else if (empty || b_pop)             starve_cnt <= '0;
    else if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid && iss_addr != '0) set_vec[iss_addr]  = 1'b1;
    if (b_pop)                       clr_vec[head.addr] = 1'b1;
  end

  // Set applied after clear so a same-cycle re-issue keeps the flag.
  always_ff @(posedge clk) begin
    if (!reset) busy_vec <= '0;
    else        busy_vec <= ((busy_vec & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_wr;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [31:0] busy_vec;
  logic        stall_a;
  logic        wr;
  logic [4:0]  addr3;
  logic [31:0] data3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk(clk), .reset(reset),
    .a_wr(a_wr), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busy_vec(busy_vec), .stall_a(stall_a),
    .wr(wr), .addr3(addr3), .data3(data3)
  );

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled 2ns later, well clear of either edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; a_wr = 0; a_addr = 0; a_data = 0;
    b_valid = 1; b_addr = 5'd3; b_data = 32'h33; iss_valid = 0; iss_addr = 0;
    #2;
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL reset_bready_low got=%0b exp=0", b_ready); end
    tick(); tick();
    #2;
    checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
    checks++; if (wr !== 1'b0 || stall_a !== 1'b0) begin failures++; $display("FAIL reset_wr_stall got=%0b%0b exp=00", wr, stall_a); end
    reset = 1'b1; b_valid = 0;
    #2;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL reset_release_bready got=%0b exp=1", b_ready); end
    checks++; if (wr !== 1'b0 || addr3 !== 5'd0 || data3 !== 32'h0) begin failures++; $display("FAIL reset_idle_port got=%0b/%0d/%h exp=0/0/0", wr, addr3, data3); end
    tick();
  endtask

  task automatic test_only_a();
    a_wr = 1; a_addr = 5'd5; a_data = 32'h1234;
    #2;
    checks++; if (wr !== 1'b1 || addr3 !== 5'd5 || data3 !== 32'h1234) begin failures++; $display("FAIL only_a got=%0b/%0d/%h exp=1/5/1234", wr, addr3, data3); end
    tick();
    a_wr = 0;
    #2;
    checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL only_a_busy got=%h exp=0", busy_vec); end
    checks++; if (wr !== 1'b0 || addr3 !== 5'd0 || data3 !== 32'h0) begin failures++; $display("FAIL idle_port got=%0b/%0d/%h exp=0/0/0", wr, addr3, data3); end
    // r0 from A never writes
    a_wr = 1; a_addr = 5'd0; a_data = 32'hDEAD;
    #1;
    checks++; if (wr !== 1'b0) begin failures++; $display("FAIL a_r0 got=%0b exp=0", wr); end
    tick();
    a_wr = 0;
  endtask

  task automatic test_only_b();
    iss_valid = 1; iss_addr = 5'd8;
    tick();
    iss_valid = 0;
    #2;
    checks++; if (busy_vec !== 32'h0000_0100) begin failures++; $display("FAIL only_b_busy_set got=%h exp=00000100", busy_vec); end
    b_valid = 1; b_addr = 5'd8; b_data = 32'hBEEF;
    #1;
    checks++; if (b_ready !== 1'b1 || wr !== 1'b0) begin failures++; $display("FAIL only_b_no_fallthru ready=%0b wr=%0b exp=1/0", b_ready, wr); end
    tick();
    b_valid = 0;
    #2;
    checks++; if (wr !== 1'b1 || addr3 !== 5'd8 || data3 !== 32'hBEEF) begin failures++; $display("FAIL only_b_commit got=%0b/%0d/%h exp=1/8/beef", wr, addr3, data3); end
    checks++; if (busy_vec !== 32'h0000_0100) begin failures++; $display("FAIL only_b_busy_hold got=%h exp=00000100", busy_vec); end
    tick();
    #2;
    checks++; if (busy_vec !== 32'h0 || wr !== 1'b0) begin failures++; $display("FAIL only_b_clear busy=%h wr=%0b exp=0/0", busy_vec, wr); end
  endtask

  task automatic test_starvation();
    a_wr = 1; a_addr = 5'd1; a_data = 32'd100;
    b_valid = 1; b_addr = 5'd12; b_data = 32'hC0DE;
    tick();
    b_valid = 0;
    for (int i = 0; i < 4; i++) begin
      a_data = 32'd200 + i;
      #2;
      checks++; if (wr !== 1'b1 || addr3 !== 5'd1 || data3 !== 32'd200 + i || stall_a !== 1'b0) begin
        failures++; $display("FAIL starve_a_win[%0d] got=%0b/%0d/%0d stall=%0b exp=1/1/%0d stall=0", i, wr, addr3, data3, stall_a, 200 + i);
      end
      tick();
    end
    #2;
    checks++; if (stall_a !== 1'b1 || wr !== 1'b1 || addr3 !== 5'd12 || data3 !== 32'hC0DE) begin
      failures++; $display("FAIL starve_stall got stall=%0b %0b/%0d/%h exp stall=1 1/12/c0de", stall_a, wr, addr3, data3);
    end
    tick();
    #2;
    checks++; if (stall_a !== 1'b0 || addr3 !== 5'd1 || data3 !== 32'd203) begin failures++; $display("FAIL starve_resume got stall=%0b %0d/%0d exp stall=0 1/203", stall_a, addr3, data3); end
    tick();
    a_wr = 0;
  endtask

  task automatic test_back_to_back();
    a_wr = 1; a_addr = 5'd2; a_data = 32'h22;
    b_valid = 1; b_addr = 5'd20; b_data = 32'hA0;
    #1;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%0b exp=1", b_ready); end
    tick();
    b_addr = 5'd21; b_data = 32'hA1;
    #1;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%0b exp=1", b_ready); end
    tick();
    b_addr = 5'd22; b_data = 32'hA2;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (b_ready !== 1'b0 || addr3 !== 5'd2) begin failures++; $display("FAIL bp_full[%0d] ready=%0b addr3=%0d exp=0/2", i, b_ready, addr3); end
      tick();
    end
    #2;
    checks++; if (stall_a !== 1'b1 || addr3 !== 5'd20 || data3 !== 32'hA0 || b_ready !== 1'b0) begin
      failures++; $display("FAIL bp_pop_full stall=%0b %0d/%h ready=%0b exp 1 20/a0 0", stall_a, addr3, data3, b_ready);
    end
    tick();
    #2;
    checks++; if (b_ready !== 1'b1 || addr3 !== 5'd2) begin failures++; $display("FAIL bp_reopen ready=%0b addr3=%0d exp=1/2", b_ready, addr3); end
    tick();
    b_valid = 0; a_wr = 0;
    #2;
    checks++; if (wr !== 1'b1 || addr3 !== 5'd21 || data3 !== 32'hA1) begin failures++; $display("FAIL bp_order1 got=%0b/%0d/%h exp=1/21/a1", wr, addr3, data3); end
    tick();
    #2;
    checks++; if (wr !== 1'b1 || addr3 !== 5'd22 || data3 !== 32'hA2) begin failures++; $display("FAIL bp_order2 got=%0b/%0d/%h exp=1/22/a2", wr, addr3, data3); end
    tick();
    #2;
    checks++; if (wr !== 1'b0) begin failures++; $display("FAIL bp_drained wr=%0b exp=0", wr); end
  endtask

  task automatic test_same_reg();
    iss_valid = 1; iss_addr = 5'd9;
    tick();
    iss_valid = 0; b_valid = 1; b_addr = 5'd9; b_data = 32'h99;
    tick();
    b_valid = 0; iss_valid = 1; iss_addr = 5'd9;
    #2;
    checks++; if (wr !== 1'b1 || addr3 !== 5'd9) begin failures++; $display("FAIL same_commit got=%0b/%0d exp=1/9", wr, addr3); end
    tick();
    iss_valid = 0;
    #2;
    checks++; if (busy_vec !== 32'h0000_0200) begin failures++; $display("FAIL same_set_wins got=%h exp=00000200", busy_vec); end
    b_valid = 1; b_addr = 5'd0; b_data = 32'h55;
    tick();
    b_valid = 0;
    #2;
    checks++; if (wr !== 1'b0 || b_ready !== 1'b1) begin failures++; $display("FAIL r0_pop wr=%0b ready=%0b exp=0/1", wr, b_ready); end
    tick();
    #2;
    checks++; if (wr !== 1'b0 || addr3 !== 5'd0 || data3 !== 32'h0) begin failures++; $display("FAIL r0_popped got=%0b/%0d/%h exp=0/0/0", wr, addr3, data3); end
    iss_valid = 1; iss_addr = 5'd0;
    tick();
    iss_valid = 0;
    #2;
    checks++; if (busy_vec !== 32'h0000_0200) begin failures++; $display("FAIL iss_r0 got=%h exp=00000200", busy_vec); end
  endtask

  task automatic test_reset_midop();
    a_wr = 1; a_addr = 5'd3; a_data = 32'h3;
    iss_valid = 1; iss_addr = 5'd25;
    b_valid = 1; b_addr = 5'd25; b_data = 32'h1;
    tick();
    iss_valid = 0; b_addr = 5'd26; b_data = 32'h2;
    tick();
    a_wr = 0; b_valid = 0; reset = 0;
    #1;
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL midop_reset_ready got=%0b exp=0", b_ready); end
    tick();
    reset = 1;
    #2;
    checks++; if (b_ready !== 1'b1 || busy_vec !== 32'h0) begin failures++; $display("FAIL midop_after ready=%0b busy=%h exp=1/0", b_ready, busy_vec); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr !== 1'b0) begin failures++; $display("FAIL midop_no_wr[%0d] got=%0b exp=0", i, wr); end
      tick(); #2;
    end
  endtask

  initial begin
    test_reset();
    test_only_a();
    test_only_b();
    test_starvation();
    test_back_to_back();
    test_same_reg();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
